// File: rtl/wfq_pkg.sv
// Shared constants and FSM encoding for the WFQ finish-time engine.
package wfq_pkg;

  localparam int LEN_W_DEF     = 16;
  localparam int FRAC_W_DEF    = 16;
  localparam int TIME_W_DEF    = 16;
  localparam int FLOW_ID_W_DEF = 13;

  // Saturation value for the default time width.
  localparam logic [TIME_W_DEF-1:0] TIME_MAX = '1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } wfq_state_t;

endpackage

// File: rtl/wfq_seq_div.sv
// Restoring divider, one quotient bit per cycle. A zero divisor finishes
// immediately with dbz set; dbz and quotient hold until the next start.
module wfq_seq_div #(
  parameter int DVD_W = 32,
  parameter int DVS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic             dbz,
  output logic [DVD_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DVD_W);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [DVD_W-1:0] qsh;
  logic [DVS_W:0]   shifted;
  logic [DVS_W:0]   trial;
  logic             qbit;
  logic [DVS_W-1:0] rem_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem, qsh[DVD_W-1]};
    trial   = shifted - {1'b0, dvs};
    qbit    = (shifted >= {1'b0, dvs});
    rem_nxt = qbit ? trial[DVS_W-1:0] : shifted[DVS_W-1:0];
  end

  // Iteration control: counter, run flag, done pulse, divide-by-zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dbz <= (divisor == '0);
        cnt <= '0;
        if (divisor == '0) begin
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          run  <= 1'b1;
        end
      end else if (run) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(DVD_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Datapath: partial remainder and the dividend/quotient shift register.
  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
      dvs <= divisor;
      qsh <= dividend;
    end else if (run) begin
      rem <= rem_nxt;
      qsh <= {qsh[DVD_W-2:0], qbit};
    end
  end

  assign quotient = qsh;

endmodule

// File: rtl/wfq_finish_time_mc.sv
// WFQ finish-time engine: F = max(V, F_last[flow]) + L/w with a per-flow
// table of F_last held in inferred RAM, cleared after every reset.
// Optional macro WFQ_FT_WRAP_EN: modular virtual time (signed-difference
// compare, wrapping add); undefined gives unsigned compare and saturation.
module wfq_finish_time_mc
  import wfq_pkg::*;
#(
  parameter int LEN_W     = LEN_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int TIME_W    = TIME_W_DEF,
  parameter int FLOW_ID_W = FLOW_ID_W_DEF,
  parameter int NUM_FLOWS = 2 ** FLOW_ID_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flow_idle,
  input  logic [LEN_W-1:0]     packet_l,
  input  logic [FRAC_W-1:0]    flow_w,
  input  logic [TIME_W-1:0]    vtime,
  input  logic [FLOW_ID_W-1:0] flow_id,
  output logic                 busy,
  output logic [TIME_W-1:0]    ftime,
  output logic                 done_ftime,
  output logic                 ovf
);

  localparam int N = LEN_W + FRAC_W;
  localparam logic [FLOW_ID_W:0]   NUM_FLOWS_V = (FLOW_ID_W + 1)'(NUM_FLOWS);
  localparam logic [FLOW_ID_W-1:0] LAST_ADDR   = FLOW_ID_W'(NUM_FLOWS - 1);
  localparam logic [TIME_W-1:0]    T_MAX       = {TIME_W{1'b1}};

  // Quotient narrowing: anything above TIME_W bits clamps to all-ones.
  function automatic logic [TIME_W:0] clamp_q(input logic [N-1:0] q);
    if (|q[N-1:TIME_W]) return {1'b1, T_MAX};
    return {1'b0, q[TIME_W-1:0]};
  endfunction

  // Saturating add of base and quotient; MSB of the result is the overflow flag.
  function automatic logic [TIME_W:0] sat_add(input logic [TIME_W-1:0] a,
                                              input logic [TIME_W-1:0] b);
    logic [TIME_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[TIME_W]) return {1'b1, T_MAX};
    return s;
  endfunction

  wfq_state_t state, state_nxt;

  logic [FLOW_ID_W-1:0] init_addr;
  logic                 rd_first;
  logic                 accept;

  logic                 idle_q;
  logic [TIME_W-1:0]    v_q;
  logic [FLOW_ID_W-1:0] fid_q;
  logic [TIME_W-1:0]    flast_q;

  logic                 div_done;
  logic                 div_dbz;
  logic [N-1:0]         quot;

  logic [TIME_W:0]      q_cl;
  logic [TIME_W-1:0]    base;
  logic [TIME_W-1:0]    sum;
  logic                 sum_ovf;
  logic [TIME_W-1:0]    ft_nxt;
  logic                 ovf_nxt;

  logic                 tbl_we;
  logic [FLOW_ID_W-1:0] tbl_waddr;
  logic [TIME_W-1:0]    tbl_wdata;
  logic [TIME_W-1:0]    tbl [0:NUM_FLOWS-1];

  assign accept = (state == ST_IDLE) && start && ({1'b0, flow_id} < NUM_FLOWS_V);
  assign busy   = (state != ST_IDLE);

  wfq_seq_div #(
    .DVD_W (N),
    .DVS_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .dividend ({packet_l, {FRAC_W{1'b0}}}),
    .divisor  (flow_w),
    .done     (div_done),
    .dbz      (div_dbz),
    .quotient (quot)
  );

  // State register, table-clear address and first-DIV-cycle read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_addr <= '0;
      rd_first  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_first <= accept;
      if (state == ST_INIT) init_addr <= init_addr + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_addr == LAST_ADDR) state_nxt = ST_IDLE;
      ST_IDLE: if (accept)                 state_nxt = ST_DIV;
      ST_DIV:  if (div_done)               state_nxt = ST_FIN;
      ST_FIN:                              state_nxt = ST_IDLE;
      default:                             state_nxt = ST_INIT;
    endcase
  end

  // Request capture; the divider takes L and w directly at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      idle_q <= flow_idle;
      v_q    <= vtime;
      fid_q  <= flow_id;
    end
  end

  // Finish-time arithmetic evaluated during FIN.
  always_comb begin
    q_cl = clamp_q(quot);
`ifdef WFQ_FT_WRAP_EN
    if (idle_q)                                   base = v_q;
    else if ($signed(flast_q - v_q) >= 0)         base = flast_q;
    else                                          base = v_q;
    sum     = base + q_cl[TIME_W-1:0];
    sum_ovf = 1'b0;
`else
    if (idle_q)              base = v_q;
    else if (flast_q > v_q)  base = flast_q;
    else                     base = v_q;
    {sum_ovf, sum} = sat_add(base, q_cl[TIME_W-1:0]);
`endif
    if (div_dbz) begin
      ft_nxt  = T_MAX;
      ovf_nxt = 1'b1;
    end else begin
      ft_nxt  = sum;
      ovf_nxt = q_cl[TIME_W] | sum_ovf;
    end
  end

  // Table write port: zero-fill during INIT, finish-time write-back in FIN.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = fid_q;
    tbl_wdata = ft_nxt;
    if (state == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_addr;
      tbl_wdata = '0;
    end else if (state == ST_FIN && !div_dbz) begin
      tbl_we    = 1'b1;
    end
  end

  // Per-flow F_last RAM: one write port, one synchronous read held in flast_q.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_waddr] <= tbl_wdata;
    if (rd_first) flast_q <= tbl[fid_q];
  end

  // Result registers; ftime and ovf hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftime      <= '0;
      ovf        <= 1'b0;
      done_ftime <= 1'b0;
    end else begin
      done_ftime <= (state == ST_FIN);
      if (state == ST_FIN) begin
        ftime <= ft_nxt;
        ovf   <= ovf_nxt;
      end
    end
  end

endmodule
